bundle_dispatcher: RTL and testbench



---
 rtl/bundle_dispatcher.sv | 156 +++++++++++++++
 tb/tb_bundle_dispatcher.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bundle_dispatcher.sv
// rtl/bundle_dispatcher.sv - holds one fetch bundle and issues its instructions in order to the ready prefix of decoder lanes
// Flattened lane outputs place lane k at slice [k*W +: W]; bundle_i places instruction 0 in the MSB slice.
module bundle_dispatcher #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int NumLanes                = 4,
  parameter int PidSize                 = 32,
  parameter int TidSize                 = 64,
  parameter int instructionCounterWidth = 64,
  parameter int LenWidth                = $clog2(NumLanes)
) (
  input  logic                                        clock_i,
  input  logic                                        resetn_i,
  input  logic                                        flush_i,
  input  logic                                        bundleValid_i,
  output logic                                        bundleReady_o,
  input  logic [NumLanes*instructionWidth-1:0]        bundle_i,
  input  logic [LenWidth-1:0]                         bundleLen_i,
  input  logic [addressWidth-1:0]                     bundleAddress_i,
  input  logic                                        is64Bit_i,
  input  logic [PidSize-1:0]                          bundlePid_i,
  input  logic [TidSize-1:0]                          bundleTid_i,
  input  logic [instructionCounterWidth-1:0]          bundleStartMajId_i,
  input  logic [NumLanes-1:0]                         laneReady_i,
  output logic [NumLanes-1:0]                         laneValid_o,
  output logic [NumLanes*instructionWidth-1:0]        laneInstr_o,
  output logic [NumLanes*addressWidth-1:0]            laneAddr_o,
  output logic [NumLanes-1:0]                         laneIs64_o,
  output logic [NumLanes*PidSize-1:0]                 lanePid_o,
  output logic [NumLanes*TidSize-1:0]                 laneTid_o,
  output logic [NumLanes*instructionCounterWidth-1:0] laneMajId_o,
  output logic [31:0]                                 stallCount_o
);

  localparam int CntWidth = $clog2(NumLanes + 1);
  localparam int BufDepth = 1 << CntWidth;
  localparam logic [addressWidth-1:0] Low32Mask = addressWidth'(64'hFFFF_FFFF);

  // Buffer is sized to a power of two so slot indices wrap cleanly; only NumLanes entries are loaded.
  logic [instructionWidth-1:0]        buf_instr [BufDepth];
  logic [CntWidth-1:0]                remain;
  logic [CntWidth-1:0]                head;
  logic [addressWidth-1:0]            buf_base;
  logic                               buf_is64;
  logic [PidSize-1:0]                 buf_pid;
  logic [TidSize-1:0]                 buf_tid;
  logic [instructionCounterWidth-1:0] buf_maj;

  logic [CntWidth-1:0]                ready_prefix;
  logic [CntWidth-1:0]                issue_count;
  logic [CntWidth-1:0]                load_count;
  logic [LenWidth-1:0]                len_clamped;
  logic [NumLanes-1:0]                issue_mask;
  logic                               run;
  logic                               accept;
  logic                               stall;
  logic [CntWidth-1:0]                lane_slot  [NumLanes];
  logic [instructionWidth-1:0]        lane_instr [NumLanes];
  logic [addressWidth-1:0]            lane_addr  [NumLanes];
  logic [instructionCounterWidth-1:0] lane_maj   [NumLanes];

  // A gap in laneReady_i ends the usable run of lanes.
  always_comb begin
    ready_prefix = '0;
    run          = 1'b1;
    for (int k = 0; k < NumLanes; k++) begin
      run          = run & laneReady_i[k];
      ready_prefix = ready_prefix + CntWidth'(run);
    end
  end

  always_comb begin
    issue_count = (remain < ready_prefix) ? remain : ready_prefix;
    for (int k = 0; k < NumLanes; k++) begin
      issue_mask[k] = CntWidth'(k) < issue_count;
      lane_slot[k]  = head + CntWidth'(k);
      lane_instr[k] = buf_instr[lane_slot[k]];
      lane_addr[k]  = buf_base + (addressWidth'(lane_slot[k]) << 2);
      if (!buf_is64) begin
        lane_addr[k] = lane_addr[k] & Low32Mask;
      end
      lane_maj[k]   = buf_maj + instructionCounterWidth'(lane_slot[k]);
    end
  end

  always_comb begin
    if ({1'b0, bundleLen_i} >= (LenWidth + 1)'(NumLanes)) begin
      len_clamped = LenWidth'(NumLanes - 1);
    end else begin
      len_clamped = bundleLen_i;
    end
    load_count    = CntWidth'(len_clamped) + 1'b1;
    bundleReady_o = !flush_i && ((remain == '0) || (remain <= ready_prefix));
    accept        = bundleValid_i && bundleReady_o;
    stall         = (remain != '0) && (ready_prefix == '0) && !flush_i;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      remain       <= '0;
      head         <= '0;
      buf_base     <= '0;
      buf_is64     <= 1'b0;
      buf_pid      <= '0;
      buf_tid      <= '0;
      buf_maj      <= '0;
      for (int i = 0; i < BufDepth; i++) begin
        buf_instr[i] <= '0;
      end
      laneValid_o  <= '0;
      laneInstr_o  <= '0;
      laneAddr_o   <= '0;
      laneIs64_o   <= '0;
      lanePid_o    <= '0;
      laneTid_o    <= '0;
      laneMajId_o  <= '0;
      stallCount_o <= '0;
    end else if (flush_i) begin
      remain      <= '0;
      head        <= '0;
      laneValid_o <= '0;
    end else begin
      laneValid_o <= issue_mask;
      for (int k = 0; k < NumLanes; k++) begin
        if (issue_mask[k]) begin
          laneInstr_o[k*instructionWidth +: instructionWidth]               <= lane_instr[k];
          laneAddr_o[k*addressWidth +: addressWidth]                        <= lane_addr[k];
          laneIs64_o[k]                                                     <= buf_is64;
          lanePid_o[k*PidSize +: PidSize]                                   <= buf_pid;
          laneTid_o[k*TidSize +: TidSize]                                   <= buf_tid;
          laneMajId_o[k*instructionCounterWidth +: instructionCounterWidth] <= lane_maj[k];
        end
      end
      // Acceptance implies the old bundle fully drains at this edge, so the load overwrites it.
      if (accept) begin
        remain   <= load_count;
        head     <= '0;
        buf_base <= bundleAddress_i;
        buf_is64 <= is64Bit_i;
        buf_pid  <= bundlePid_i;
        buf_tid  <= bundleTid_i;
        buf_maj  <= bundleStartMajId_i;
        for (int i = 0; i < NumLanes; i++) begin
          buf_instr[i] <= bundle_i[(NumLanes-1-i)*instructionWidth +: instructionWidth];
        end
      end else begin
        remain <= remain - issue_count;
        head   <= head + issue_count;
      end
      if (stall && (stallCount_o != 32'hFFFF_FFFF)) begin
        stallCount_o <= stallCount_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_bundle_dispatcher.sv
// tb/tb_bundle_dispatcher.sv - randomized bench for bundle_dispatcher against a queue-based reference model
module tb_bundle_dispatcher;

  localparam int N  = 4;
  localparam int IW = 32;
  localparam int AW = 64;
  localparam int PW = 32;
  localparam int TW = 64;
  localparam int MW = 64;
  localparam int LW = 2;

  logic            clock_i = 1'b0;
  logic            resetn_i = 1'b0;
  logic            flush_i = 1'b0;
  logic            bundleValid_i = 1'b0;
  logic            bundleReady_o;
  logic [N*IW-1:0] bundle_i = '0;
  logic [LW-1:0]   bundleLen_i = '0;
  logic [AW-1:0]   bundleAddress_i = '0;
  logic            is64Bit_i = 1'b0;
  logic [PW-1:0]   bundlePid_i = '0;
  logic [TW-1:0]   bundleTid_i = '0;
  logic [MW-1:0]   bundleStartMajId_i = '0;
  logic [N-1:0]    laneReady_i = '1;
  logic [N-1:0]    laneValid_o;
  logic [N*IW-1:0] laneInstr_o;
  logic [N*AW-1:0] laneAddr_o;
  logic [N-1:0]    laneIs64_o;
  logic [N*PW-1:0] lanePid_o;
  logic [N*TW-1:0] laneTid_o;
  logic [N*MW-1:0] laneMajId_o;
  logic [31:0]     stallCount_o;

  always #5 clock_i = ~clock_i;

  bundle_dispatcher dut (
    .clock_i(clock_i), .resetn_i(resetn_i), .flush_i(flush_i),
    .bundleValid_i(bundleValid_i), .bundleReady_o(bundleReady_o),
    .bundle_i(bundle_i), .bundleLen_i(bundleLen_i), .bundleAddress_i(bundleAddress_i),
    .is64Bit_i(is64Bit_i), .bundlePid_i(bundlePid_i), .bundleTid_i(bundleTid_i),
    .bundleStartMajId_i(bundleStartMajId_i), .laneReady_i(laneReady_i),
    .laneValid_o(laneValid_o), .laneInstr_o(laneInstr_o), .laneAddr_o(laneAddr_o),
    .laneIs64_o(laneIs64_o), .lanePid_o(lanePid_o), .laneTid_o(laneTid_o),
    .laneMajId_o(laneMajId_o), .stallCount_o(stallCount_o)
  );

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] addr;
    logic          is64;
    logic [PW-1:0] pid;
    logic [TW-1:0] tid;
    logic [MW-1:0] maj;
  } item_t;

  item_t         pending[$];
  logic [N-1:0]  e_valid;
  item_t         e_lane [N];
  logic [31:0]   e_stall;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ready_run(input logic [N-1:0] r);
    int p = 0;
    while (p < N && r[p]) p++;
    return p;
  endfunction

  function automatic logic exp_ready();
    return !flush_i && (pending.size() <= ready_run(laneReady_i));
  endfunction

  task automatic model_reset();
    pending.delete();
    e_valid = '0;
    e_stall = '0;
    for (int k = 0; k < N; k++) e_lane[k] = '{default: '0};
  endtask

  task automatic model_edge();
    int p, held, n, len;
    logic [31:0] a32;
    item_t it;
    p    = ready_run(laneReady_i);
    held = pending.size();
    e_valid = '0;
    if (flush_i) begin
      pending.delete();
    end else begin
      n = (held < p) ? held : p;
      for (int k = 0; k < n; k++) begin
        e_lane[k]  = pending.pop_front();
        e_valid[k] = 1'b1;
      end
      if (held > 0 && p == 0 && e_stall != 32'hFFFF_FFFF) e_stall++;
      if (bundleValid_i && held <= p) begin
        len = (int'(bundleLen_i) >= N) ? N - 1 : int'(bundleLen_i);
        for (int i = 0; i <= len; i++) begin
          it.instr = bundle_i[(N-1-i)*IW +: IW];
          if (is64Bit_i) begin
            it.addr = bundleAddress_i + 64'(4 * i);
          end else begin
            a32     = bundleAddress_i[31:0] + 32'(4 * i);
            it.addr = {32'h0, a32};
          end
          it.is64 = is64Bit_i;
          it.pid  = bundlePid_i;
          it.tid  = bundleTid_i;
          it.maj  = bundleStartMajId_i + 64'(i);
          pending.push_back(it);
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check("valid", 64'(laneValid_o), 64'(e_valid));
    check("stall", 64'(stallCount_o), 64'(e_stall));
    for (int k = 0; k < N; k++) begin
      check($sformatf("instr%0d", k), 64'(laneInstr_o[k*IW +: IW]), 64'(e_lane[k].instr));
      check($sformatf("addr%0d", k), laneAddr_o[k*AW +: AW], e_lane[k].addr);
      check($sformatf("is64_%0d", k), 64'(laneIs64_o[k]), 64'(e_lane[k].is64));
      check($sformatf("pid%0d", k), 64'(lanePid_o[k*PW +: PW]), 64'(e_lane[k].pid));
      check($sformatf("tid%0d", k), laneTid_o[k*TW +: TW], e_lane[k].tid);
      check($sformatf("maj%0d", k), laneMajId_o[k*MW +: MW], e_lane[k].maj);
    end
  endtask

  task automatic step();
    #1;
    check("ready", 64'(bundleReady_o), 64'(exp_ready()));
    model_edge();
    @(posedge clock_i);
    #1;
    compare_outputs();
  endtask

  task automatic offer(input int len, input logic [63:0] base, input logic is64, input logic [63:0] maj);
    bundleValid_i      = 1'b1;
    bundleLen_i        = LW'(len);
    bundleAddress_i    = base;
    is64Bit_i          = is64;
    bundleStartMajId_i = maj;
    bundlePid_i        = $urandom;
    bundleTid_i        = {$urandom, $urandom};
    for (int i = 0; i < N; i++) bundle_i[i*IW +: IW] = $urandom;
  endtask

  task automatic do_reset();
    resetn_i = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    #1;
    resetn_i = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock_i);
    #1;
    compare_outputs();
    resetn_i = 1'b1;
    #1;
    check("ready_after_reset", 64'(bundleReady_o), 64'd1);

    // Full-width bundle, all lanes ready.
    laneReady_i = 4'b1111;
    offer(3, 64'h1000, 1'b1, 64'd10);
    step();
    bundleValid_i = 1'b0;
    step();
    check("s035_valid", 64'(laneValid_o), 64'hF);
    check("s035_addr3", laneAddr_o[3*AW +: AW], 64'h100C);
    check("s035_maj3", laneMajId_o[3*MW +: MW], 64'd13);

    // Two ready lanes, three instructions.
    laneReady_i = 4'b0011;
    offer(2, 64'h2000, 1'b1, 64'd100);
    step();
    bundleValid_i = 1'b0;
    step();
    step();
    check("s036_valid", 64'(laneValid_o), 64'h1);
    check("s036_addr0", laneAddr_o[0 +: AW], 64'h2008);

    // Stall counting, then flush with a competing offer.
    do_reset();
    laneReady_i = 4'b1111;
    offer(3, 64'h3000, 1'b1, 64'd0);
    step();
    bundleValid_i = 1'b0;
    laneReady_i   = 4'b0000;
    repeat (5) step();
    check("s037_stall", 64'(stallCount_o), 64'd5);
    laneReady_i = 4'b0011;
    step();
    flush_i = 1'b1;
    offer(1, 64'h4000, 1'b1, 64'd50);
    step();
    check("s039_valid", 64'(laneValid_o), 64'h0);
    flush_i = 1'b0;
    bundleValid_i = 1'b0;
    step();
    check("s039_ready", 64'(bundleReady_o), 64'd1);

    // 32-bit address wrap and majID wrap; upper address bits must be cleared.
    laneReady_i = 4'b1111;
    offer(1, 64'hABCD_0000_FFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    bundleValid_i = 1'b0;
    step();
    check("s038_addr0", laneAddr_o[0 +: AW], 64'h0000_0000_FFFF_FFFC);
    check("s038_addr1", laneAddr_o[1*AW +: AW], 64'h0);
    check("s038_maj1", laneMajId_o[1*MW +: MW], 64'h0);

    // Asynchronous reset in the middle of a drain.
    laneReady_i = 4'b0001;
    offer(3, 64'h5000, 1'b1, 64'd7);
    step();
    bundleValid_i = 1'b0;
    step();
    #2;
    do_reset();
    laneReady_i = 4'b1111;
    repeat (4) step();

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      laneReady_i = ($urandom_range(0, 2) == 0) ? N'($urandom) : 4'b1111;
      flush_i     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) < 7) begin
        offer($urandom_range(0, N - 1),
              ($urandom_range(0, 3) == 0) ? {$urandom, 32'hFFFF_FFF0} : {$urandom, $urandom},
              1'($urandom),
              ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom});
      end else begin
        bundleValid_i = 1'b0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
